// File: rtl/zynq_pkg.sv
// System instance values for the Zynq shell reverse path, plus a small width helper.
package zynq_pkg;

   localparam int unsigned rev_num_chan_gp = 5;
   localparam int unsigned rev_width_gp    = 32;
   localparam logic [rev_num_chan_gp-1:0] rev_use_credits_gp = 5'b00001;
   localparam int unsigned max_credits_gp  = 32;

   // Index width that never collapses to zero bits for a single-entry range.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: priority starts at ptr and wraps; ptr moves past each granted requester.
module bsg_arb_round_robin #(
   parameter  int unsigned width_p = 5,
   localparam int unsigned lg_lp   = (width_p > 1) ? $clog2(width_p) : 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] reqs_i,
   input  logic               yumi_i,
   output logic [width_p-1:0] grants_o,
   output logic [lg_lp-1:0]   grant_idx_o,
   output logic               v_o
);

   logic [lg_lp-1:0] ptr_q, ptr_d;
   logic             found_c;

   // Scan requesters from ptr upward with wrap; grant only when the consumer takes it.
   always_comb begin
      int unsigned idx;
      idx         = 0;
      found_c     = 1'b0;
      grant_idx_o = '0;
      grants_o    = '0;
      ptr_d       = ptr_q;
      for (int unsigned i = 0; i < width_p; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= width_p) idx = idx - width_p;
         if (!found_c && reqs_i[lg_lp'(idx)]) begin
            found_c     = 1'b1;
            grant_idx_o = lg_lp'(idx);
         end
      end
      v_o = found_c & yumi_i;
      if (v_o) begin
         grants_o[grant_idx_o] = 1'b1;
         ptr_d = (grant_idx_o == lg_lp'(width_p - 1)) ? '0 : grant_idx_o + lg_lp'(1);
      end
   end

   // Pointer register.
   always_ff @(posedge clk_i) begin
      if (reset_i) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/zynq_rev_credit_arb.sv
// Reverse-path (PL->PS) arbiter with per-channel credit gating and a registered output beat.
module zynq_rev_credit_arb
   import zynq_pkg::*;
#(
   parameter  int unsigned num_chan_p               = rev_num_chan_gp,
   parameter  int unsigned width_p                  = rev_width_gp,
   parameter  logic [num_chan_p-1:0] use_credits_p  = num_chan_p'(rev_use_credits_gp),
   parameter  int unsigned max_credits_p            = max_credits_gp,
   localparam int unsigned credit_lg_lp             = $clog2(max_credits_p + 1),
   localparam int unsigned chan_lg_lp               = clog2_min1(num_chan_p)
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic [num_chan_p-1:0]              v_i,
   input  logic [num_chan_p*width_p-1:0]      data_i,
   output logic [num_chan_p-1:0]              yumi_o,
   output logic                               v_o,
   output logic [width_p-1:0]                 data_o,
   output logic [chan_lg_lp-1:0]              chan_o,
   input  logic                               ready_and_i,
   input  logic [num_chan_p-1:0]              credit_v_i,
   output logic [num_chan_p*credit_lg_lp-1:0] credits_o,
   output logic                               overflow_o
);

   localparam logic [credit_lg_lp-1:0] max_cnt_lp = credit_lg_lp'(max_credits_p);

   logic [num_chan_p-1:0]   elig_c;
   logic [num_chan_p-1:0]   grant_c;
   logic [chan_lg_lp-1:0]   grant_idx_c;
   logic                    grant_v_c;
   logic                    load_c;
   logic [credit_lg_lp-1:0] cnt_c [num_chan_p];
   logic [num_chan_p-1:0]   ovf_evt_c;

   logic                    v_q, v_d;
   logic [width_p-1:0]      data_q, data_d;
   logic [chan_lg_lp-1:0]   chan_q, chan_d;
   logic                    overflow_q, overflow_d;

   // Output register can take a new beat when empty or draining; nothing is taken during reset.
   always_comb load_c = (~v_q | ready_and_i) & ~reset_i;

   for (genvar k = 0; k < num_chan_p; k++) begin : g_chan
      if (use_credits_p[k]) begin : g_credit
         logic [credit_lg_lp-1:0] cnt_q, cnt_d;
         logic                    ovf_c;

         // Up/down credit count; a return into a full counter is flagged instead of wrapping.
         always_comb begin
            cnt_d = cnt_q;
            ovf_c = 1'b0;
            unique case ({yumi_o[k], credit_v_i[k]})
               2'b10: cnt_d = cnt_q - credit_lg_lp'(1);
               2'b01: begin
                  if (cnt_q == max_cnt_lp) ovf_c = 1'b1;
                  else                     cnt_d = cnt_q + credit_lg_lp'(1);
               end
               default: cnt_d = cnt_q;
            endcase
         end

         // Credit counter register, full after reset.
         always_ff @(posedge clk_i) begin
            if (reset_i) cnt_q <= max_cnt_lp;
            else         cnt_q <= cnt_d;
         end

         assign cnt_c[k]     = cnt_q;
         assign ovf_evt_c[k] = ovf_c;
      end else begin : g_free
         logic unused_credit_c;
         assign unused_credit_c = credit_v_i[k];
         assign cnt_c[k]        = max_cnt_lp;
         assign ovf_evt_c[k]    = 1'b0;
      end

      assign elig_c[k] = v_i[k] & (~use_credits_p[k] | (cnt_c[k] != '0));
      assign credits_o[k*credit_lg_lp +: credit_lg_lp] = cnt_c[k];
   end

   bsg_arb_round_robin #(
      .width_p (num_chan_p)
   ) u_rr (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .reqs_i      (elig_c),
      .yumi_i      (load_c),
      .grants_o    (grant_c),
      .grant_idx_o (grant_idx_c),
      .v_o         (grant_v_c)
   );

   assign yumi_o = grant_c;

   // Next output beat: load the granted channel, go empty on no grant, hold under backpressure.
   always_comb begin
      v_d        = v_q;
      data_d     = data_q;
      chan_d     = chan_q;
      overflow_d = overflow_q | (|ovf_evt_c);
      if (load_c) begin
         v_d = grant_v_c;
         if (grant_v_c) begin
            chan_d = grant_idx_c;
            for (int unsigned k = 0; k < num_chan_p; k++) begin
               if (chan_lg_lp'(k) == grant_idx_c) data_d = data_i[k*width_p +: width_p];
            end
         end
      end
   end

   // Output stage and sticky overflow registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         v_q        <= 1'b0;
         data_q     <= '0;
         chan_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         v_q        <= v_d;
         data_q     <= data_d;
         chan_q     <= chan_d;
         overflow_q <= overflow_d;
      end
   end

   assign v_o        = v_q;
   assign data_o     = data_q;
   assign chan_o     = chan_q;
   assign overflow_o = overflow_q;

endmodule
